// File: rtl/neural_frame_pkg.sv
//------------------------------------------------------------------------------
// neural_frame_pkg : shared constants and helpers for the neural frame packer
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package neural_frame_pkg;

  localparam logic [15:0] HDR_MAGIC_DEFAULT = 16'hC691;
  localparam int          HDR_MAGIC_W       = 16;
  localparam int          HDR_SEQ_W         = 16;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
//------------------------------------------------------------------------------
// sync_fifo_fwft : single-clock first-word-fall-through FIFO, head word on out_data
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sync_fifo_fwft
  import neural_frame_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  output logic [WIDTH-1:0]        out_data,
  output logic                    empty,
  output logic                    full,
  output logic [clog2(DEPTH):0]   level
);

  localparam int AW    = clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  // Caller guarantees push only when not full (or popping) and pop only when not empty.
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  assign out_data = mem_q[rd_ptr_q];
  assign empty    = (level_q == '0);
  assign full     = (level_q == LVL_W'(DEPTH));
  assign level    = level_q;

endmodule

`default_nettype wire

// File: rtl/neural_frame_packer.sv
//------------------------------------------------------------------------------
// neural_frame_packer : frames 16-bit samples, prepends sequence headers, packs
// pairs into 32-bit words and buffers them with sticky overflow tracking.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module neural_frame_packer
  import neural_frame_pkg::*;
#(
  parameter int          FRAME_WORDS = 64,
  parameter int          FIFO_DEPTH  = 1024,
  parameter logic [15:0] HDR_MAGIC   = HDR_MAGIC_DEFAULT
) (
  input  logic                        dataclk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [15:0]                 in_data,
  input  logic                        in_wen,
  output logic [31:0]                 out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  input  logic                        overflow_clr,
  output logic                        fifo_overflow,
  output logic [15:0]                 drop_count,
  output logic [clog2(FIFO_DEPTH):0]  fifo_level,
  output logic [HDR_SEQ_W-1:0]        frame_seq
);

  localparam int                IDX_W    = clog2(FRAME_WORDS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FRAME_WORDS - 1);

  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [15:0]          low_q, low_d;
  logic [HDR_SEQ_W-1:0] seq_q, seq_d;
  logic                 ovf_q, ovf_d;
  logic [15:0]          cnt_q, cnt_d;

  logic        push_req, push_ok, drop, pop, fifo_empty, fifo_full;
  logic [31:0] push_word;

  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;

  always_comb begin
    push_req  = 1'b0;
    push_word = '0;
    idx_d     = idx_q;
    low_d     = low_q;
    seq_d     = seq_q;
    if (!enable) begin
      idx_d = '0;
      low_d = '0;
    end else if (in_wen) begin
      if (idx_q == '0) begin
        push_req  = 1'b1;
        push_word = {HDR_MAGIC, seq_q};
        seq_d     = seq_q + 1'b1;
        low_d     = in_data;
      end else if (idx_q[0]) begin
        push_req  = 1'b1;
        push_word = {in_data, low_q};
      end else begin
        low_d = in_data;
      end
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end
  end

  // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
  assign push_ok = push_req & (~fifo_full | pop);
  assign drop    = push_req & ~push_ok;

  always_comb begin
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    if (overflow_clr) begin
      ovf_d = 1'b0;
      cnt_d = '0;
    end
    if (drop) begin
      ovf_d = 1'b1;
      if (overflow_clr)          cnt_d = 16'd1;
      else if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge dataclk) begin
    if (reset) begin
      idx_q <= '0;
      low_q <= '0;
      seq_q <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      idx_q <= idx_d;
      low_q <= low_d;
      seq_q <= seq_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
    end
  end

  sync_fifo_fwft #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (dataclk),
    .rst       (reset),
    .push      (push_ok),
    .push_data (push_word),
    .pop       (pop),
    .out_data  (out_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (fifo_level)
  );

  assign fifo_overflow = ovf_q;
  assign drop_count    = cnt_q;
  assign frame_seq     = seq_q;

endmodule

`default_nettype wire

// File: tb/tb_neural_frame_packer.sv
//------------------------------------------------------------------------------
// tb_neural_frame_packer : scenario tasks plus randomized run against a queue model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_neural_frame_packer;

  localparam int FW    = 4;
  localparam int DEPTH = 4;
  localparam logic [15:0] MAGIC = 16'hC691;

  logic        clk = 1'b0;
  logic        reset, enable, in_wen, out_ready, overflow_clr;
  logic [15:0] in_data;
  logic [31:0] out_data;
  logic        out_valid, fifo_overflow;
  logic [15:0] drop_count, frame_seq;
  logic [2:0]  fifo_level;

  int total = 0;
  int bad   = 0;

  neural_frame_packer #(.FRAME_WORDS(FW), .FIFO_DEPTH(DEPTH), .HDR_MAGIC(MAGIC)) dut (
    .dataclk(clk), .reset(reset), .enable(enable), .in_data(in_data), .in_wen(in_wen),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overflow_clr(overflow_clr), .fifo_overflow(fifo_overflow), .drop_count(drop_count),
    .fifo_level(fifo_level), .frame_seq(frame_seq)
  );

  always #5 clk = ~clk;

  // Reference model: frame position, sequence, held half and an ideal bounded queue.
  logic [31:0] m_q[$];
  logic [31:0] got[$];
  int          m_pos, m_seq, m_drops;
  logic [15:0] m_held;
  bit          m_ovf;

  function automatic void model_step(bit rs, bit en, bit wen, logic [15:0] d, bit rdy, bit clr);
    bit pop, have, drp;
    logic [31:0] item;
    if (rs) begin
      m_q.delete(); m_pos = 0; m_seq = 0; m_held = '0; m_ovf = 0; m_drops = 0;
      return;
    end
    pop = rdy && (m_q.size() > 0);
    have = 0; item = '0;
    if (!en) m_pos = 0;
    else if (wen) begin
      if (m_pos == 0) begin
        item = {MAGIC, 16'(m_seq)}; have = 1; m_seq = (m_seq + 1) % 65536; m_held = d;
      end else if (m_pos % 2 == 1) begin
        item = {d, m_held}; have = 1;
      end else m_held = d;
      m_pos = (m_pos + 1) % FW;
    end
    drp = have && (m_q.size() >= DEPTH) && !pop;
    if (clr) begin m_ovf = 0; m_drops = 0; end
    if (drp) begin m_ovf = 1; if (m_drops < 65535) m_drops++; end
    if (pop) void'(m_q.pop_front());
    if (have && !drp) m_q.push_back(item);
  endfunction

  task automatic drive(bit rs, bit en, bit wen, logic [15:0] d, bit rdy, bit clr);
    reset = rs; enable = en; in_wen = wen; in_data = d; out_ready = rdy; overflow_clr = clr;
    if (!rs && out_valid && rdy) got.push_back(out_data);
    @(posedge clk);
    model_step(rs, en, wen, d, rdy, clr);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 16'h0, 0, 0);
    drive(1, 0, 0, 16'h0, 0, 0);
    got.delete();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
    total++; if (frame_seq !== 16'd0) begin bad++; $display("FAIL reset_seq got=%0d exp=0", frame_seq); end
    total++; if (fifo_overflow !== 1'b0 || drop_count !== 16'd0) begin
      bad++; $display("FAIL reset_ovf got=%0b/%0d exp=0/0", fifo_overflow, drop_count); end
  endtask

  task automatic test_single_frame();
    logic [31:0] exp [3];
    exp[0] = 32'hC6910000; exp[1] = 32'h00020001; exp[2] = 32'h00040003;
    do_reset();
    for (int i = 1; i <= 4; i++) drive(0, 1, 1, 16'(i), 1, 0);
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 16'h0, 1, 0);
    total++; if (got.size() != 3) begin bad++; $display("FAIL single_count got=%0d exp=3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL single_word%0d got=%h exp=%h", i, got[i], exp[i]); end
    end
    total++; if (frame_seq !== 16'd1) begin bad++; $display("FAIL single_seq got=%0d exp=1", frame_seq); end
  endtask

  task automatic test_three_frames();
    logic [31:0] exp[$];
    do_reset();
    for (int f = 0; f < 3; f++) begin
      int b = f * 4;
      exp.push_back({MAGIC, 16'(f)});
      exp.push_back({16'(b + 2), 16'(b + 1)});
      exp.push_back({16'(b + 4), 16'(b + 3)});
    end
    for (int i = 1; i <= 12; i++) drive(0, 1, 1, 16'(i), 1, 0);
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 16'h0, 1, 0);
    total++; if (got.size() != 9) begin bad++; $display("FAIL frames_count got=%0d exp=9", got.size()); end
    for (int i = 0; i < 9 && i < got.size(); i++) begin
      total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL frames_word%0d got=%h exp=%h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] exp [4];
    exp[0] = 32'hC6910000; exp[1] = 32'h00120011; exp[2] = 32'h00140013; exp[3] = 32'hC6910001;
    do_reset();
    for (int i = 1; i <= 8; i++) drive(0, 1, 1, 16'(16'h10 + i), 0, 0);
    total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL ovf_level got=%0d exp=4", fifo_level); end
    total++; if (fifo_overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0b exp=1", fifo_overflow); end
    total++; if (drop_count !== 16'd2) begin bad++; $display("FAIL ovf_drops got=%0d exp=2", drop_count); end
    total++; if (frame_seq !== 16'd2) begin bad++; $display("FAIL ovf_seq got=%0d exp=2", frame_seq); end
    for (int i = 0; i < 6; i++) drive(0, 1, 0, 16'h0, 1, 0);
    total++; if (got.size() != 4) begin bad++; $display("FAIL ovf_drain_count got=%0d exp=4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL ovf_word%0d got=%h exp=%h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 1; i <= 5; i++) drive(0, 1, 1, 16'(16'h0A00 + i), 0, 0);
    total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL full_level_pre got=%0d exp=4", fifo_level); end
    drive(0, 1, 1, 16'h0A06, 1, 0);
    total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL full_level_post got=%0d exp=4", fifo_level); end
    total++; if (fifo_overflow !== 1'b0 || drop_count !== 16'd0) begin
      bad++; $display("FAIL full_no_drop got=%0b/%0d exp=0/0", fifo_overflow, drop_count); end
    total++; if (out_data !== 32'h0A020A01) begin bad++; $display("FAIL full_head got=%h exp=0a020a01", out_data); end
  endtask

  task automatic test_enable_drop();
    logic [31:0] exp [4];
    exp[0] = 32'hC6910000; exp[1] = 32'hC6910001; exp[2] = 32'h00220021; exp[3] = 32'h00240023;
    do_reset();
    drive(0, 1, 1, 16'h00EE, 1, 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 16'h0BAD, 1, 0);
    for (int i = 1; i <= 4; i++) drive(0, 1, 1, 16'(16'h20 + i), 1, 0);
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 16'h0, 1, 0);
    total++; if (got.size() != 4) begin bad++; $display("FAIL en_count got=%0d exp=4", got.size()); end
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      total++; if (got[i] !== exp[i]) begin bad++; $display("FAIL en_word%0d got=%h exp=%h", i, got[i], exp[i]); end
    end
  endtask

  task automatic test_clr_and_reset();
    do_reset();
    for (int i = 1; i <= 5; i++) drive(0, 1, 1, 16'(i), 0, 0);
    drive(0, 1, 1, 16'h0006, 0, 1);
    total++; if (fifo_overflow !== 1'b1 || drop_count !== 16'd1) begin
      bad++; $display("FAIL clr_drop got=%0b/%0d exp=1/1", fifo_overflow, drop_count); end
    drive(0, 1, 0, 16'h0, 0, 1);
    total++; if (fifo_overflow !== 1'b0 || drop_count !== 16'd0) begin
      bad++; $display("FAIL clr_only got=%0b/%0d exp=0/0", fifo_overflow, drop_count); end
    drive(0, 1, 1, 16'h0007, 0, 0);
    drive(1, 1, 1, 16'h0008, 0, 0);
    total++; if (out_valid !== 1'b0 || fifo_level !== 3'd0 || frame_seq !== 16'd0) begin
      bad++; $display("FAIL midreset got=v%0b l%0d s%0d exp=v0 l0 s0", out_valid, fifo_level, frame_seq); end
    drive(0, 1, 1, 16'h0009, 0, 0);
    total++; if (out_data !== 32'hC6910000 || out_valid !== 1'b1) begin
      bad++; $display("FAIL midreset_restart got=%h v%0b exp=c6910000 v1", out_data, out_valid); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      bit rs  = ($urandom % 400) == 0;
      bit en  = ($urandom % 8) != 0;
      bit wen = ($urandom % 4) != 0;
      bit rdy = ($urandom % 3) != 0;
      bit clr = ($urandom % 60) == 0;
      drive(rs, en, wen, 16'($urandom), rdy, clr);
      total++; if (out_valid !== (m_q.size() > 0)) begin
        bad++; $display("FAIL rnd_valid c=%0d got=%0b exp=%0b", c, out_valid, m_q.size() > 0); end
      if (m_q.size() > 0) begin
        total++; if (out_data !== m_q[0]) begin bad++; $display("FAIL rnd_data c=%0d got=%h exp=%h", c, out_data, m_q[0]); end
      end
      total++; if (fifo_level !== 3'(m_q.size())) begin
        bad++; $display("FAIL rnd_level c=%0d got=%0d exp=%0d", c, fifo_level, m_q.size()); end
      total++; if (fifo_overflow !== m_ovf || drop_count !== 16'(m_drops)) begin
        bad++; $display("FAIL rnd_ovf c=%0d got=%0b/%0d exp=%0b/%0d", c, fifo_overflow, drop_count, m_ovf, m_drops); end
      total++; if (frame_seq !== 16'(m_seq)) begin
        bad++; $display("FAIL rnd_seq c=%0d got=%0d exp=%0d", c, frame_seq, m_seq); end
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; in_wen = 1'b0; in_data = '0; out_ready = 1'b0; overflow_clr = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_frame();
    test_three_frames();
    test_overflow();
    test_full_push_pop();
    test_enable_drop();
    test_clr_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/neural_frame_packer.md
Name: neural_frame_packer

Overview:
- Sits between the SPI_4x 16-bit sample stream (FIFO_DATA_STREAM / FIFO_DATA_STREAM_WEN) and the host-side 32-bit read path.
- Groups fixed-length frames of 16-bit words and prepends a 32-bit header carrying a sequence number to each frame.
- Packs word pairs into 32-bit words and buffers them in an internal FIFO, presented as a valid/ready stream.
- Drives the sticky fifo_overflow flag that feeds OVERFLOW_LED.

Parameters:
- FRAME_WORDS, 64, number of 16-bit words per frame; must be even and ≥2.
- FIFO_DEPTH, 1024, 32-bit entries in the buffer; power of 2.
- HDR_MAGIC, 16'hC691, upper half of every header word.

Ports:
- dataclk  in  1  the single clock for the block (SPI data clock).
- reset  in  1  synchronous, active-high.
- enable  in  1  SPI_running; while low, input words are ignored and framing is held at word 0.
- in_data  in  16  sample word.
- in_wen  in  1  in_data valid this cycle; at most one word per cycle.
- out_data  out  32  FIFO head word.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_data this cycle.
- overflow_clr  in  1  clears the sticky overflow flag and the drop count.
- fifo_overflow  out  1  sticky; set when any push is dropped.
- drop_count  out  16  pushes dropped since the last clear; saturates at 16'hFFFF.
- fifo_level  out  log2(FIFO_DEPTH)+1  current occupancy.
- frame_seq  out  16  sequence number of the next header to be emitted.

Behaviour:
- Reset (synchronous, dataclk edge with reset=1):
  - FIFO emptied; out_valid=0; fifo_level=0.
  - word index=0; held low half cleared; frame_seq=0.
  - fifo_overflow=0; drop_count=0.
  - out_data is don't-care while out_valid=0.
- Accepted word: in_wen=1 and enable=1. The word index counts 0..FRAME_WORDS-1 and wraps to 0.
- Index 0:
  - Push header {HDR_MAGIC, frame_seq}.
  - Latch in_data as the low half.
  - Increment frame_seq, wrapping 16'hFFFF→0.
- Odd index: push {in_data, held_low}, so the earlier word goes in bits 15:0.
- Even index ≠0: latch in_data as the low half; no push.
- At most one push per cycle follows from the rules above.
- enable=0:
  - Accepted input is ignored and the index is forced to 0.
  - A held half-pair is discarded and no partial word is pushed.
  - FIFO drain continues.
- Pop: out_valid & out_ready. FIFO is first-word-fall-through.
  - A word pushed into an empty FIFO appears on out_data with out_valid=1 on the next cycle (1-cycle latency).
- Push acceptance: accepted if fifo_level<FIFO_DEPTH, or if a pop occurs in the same cycle (simultaneous push and pop when full keeps level at FIFO_DEPTH).
- Dropped push:
  - The data is discarded, fifo_overflow←1, drop_count increments (saturating).
  - The index still advances, so frame alignment is preserved. A dropped header still consumes its frame_seq value, so the host detects the gap.
- overflow_clr:
  - Clears fifo_overflow and drop_count.
  - If a drop occurs in the same cycle, the drop wins: flag=1, count=1.
- Simultaneous push and pop with the FIFO empty: the pushed word is not bypassed. out_valid rises the next cycle.
- fifo_level is registered and reflects pushes/pops from the previous edge.
- Reset mid-frame: partial pair and all FIFO contents are lost; the next accepted word is treated as index 0 with seq 0.

Decomposition:
- Shared package neural_frame_pkg:
  - HDR_MAGIC default.
  - Header field widths (magic 16, seq 16).
  - Function clog2 for the level width.
- One sub-module: sync_fifo_fwft (single-clock, parameterised width/depth). It provides push/pop/full/empty/level; the packer holds the framing FSM.

Test Plan:
- FRAME_WORDS=4, enable=1, feed 16'h0001..16'h0004 with out_ready=1 → out stream C6910000, 00020001, 00040003; frame_seq=1.
- Feed 3 frames (12 words, FRAME_WORDS=4) → headers C6910000, C6910001, C6910002, each followed by its two data words in order.
- FIFO_DEPTH=4, out_ready=0, feed 2 frames → first 4 words stored; remaining 2 pushes dropped; fifo_overflow=1; drop_count=2; after draining, the 4 stored words are intact.
- With fifo_level=FIFO_DEPTH, pop and push in the same cycle → no drop; level stays 4; fifo_overflow unchanged.
- Feed 1 word, drop enable for 3 cycles, re-enable, feed 4 words → output is header C6910001 (seq 1) plus two packed pairs from the new words; the orphan half never appears.
- Assert overflow_clr in the same cycle as a drop → fifo_overflow=1, drop_count=1. Assert reset mid-frame → next cycle out_valid=0, fifo_level=0, frame_seq=0.
